// File: rtl/pipe_stage_register.sv
// pipe_stage_register: elastic valid/ready pipeline stage with flush; define PIPE_SKID_EN for the two-entry skid build
module pipe_stage_register #(
  parameter int WIDTH = 96,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE = 2'd1;
  logic [1:0] state_q, state_d;
  logic valid_q;
  logic [WIDTH-1:0] main_q, main_d;
  logic accept, fire;
  assign accept = in_valid_i & in_ready_o & ~flush_i;
  assign fire = valid_q & out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o = main_q;
  assign count_o = state_q;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] FULL = 2'd2;
  logic ready_q;
  logic [WIDTH-1:0] skid_q, skid_d;
  assign in_ready_o = ready_q;
  // Occupancy transitions and data movement; skid drains into main when main fires.
  always_comb begin
    state_d = flush_i ? EMPTY :
              (state_q == EMPTY) ? (accept ? ONE : EMPTY) :
              (state_q == ONE) ? ((accept & ~fire) ? FULL : (~accept & fire) ? EMPTY : ONE) :
              (fire ? ONE : FULL);
    main_d = (accept & ((state_q == EMPTY) | fire)) ? in_data_i :
             ((state_q == FULL) & fire & ~flush_i) ? skid_q : main_q;
    skid_d = (accept & (state_q == ONE) & ~fire) ? in_data_i : skid_q;
  end
  // Registered ready and skid payload; ready depends only on next occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q <= 1'b1;
      skid_q <= RESET_DATA;
    end else begin
      ready_q <= state_d != FULL;
      skid_q <= skid_d;
    end
  end
`else
  assign in_ready_o = ~valid_q | out_ready_i;
  // Single-entry occupancy: a new beat can replace the one leaving in the same cycle.
  always_comb begin
    state_d = flush_i ? EMPTY : accept ? ONE : fire ? EMPTY : state_q;
    main_d = accept ? in_data_i : main_q;
  end
`endif
  // Main register and occupancy; flush clears only valid state, never payload.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      main_q <= RESET_DATA;
    end else begin
      state_q <= state_d;
      valid_q <= state_d != EMPTY;
      main_q <= main_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_register.sv
// tb_pipe_stage_register: scoreboard bench comparing the stage against an ideal FIFO of capacity 1 or 2
module tb_pipe_stage_register;
  localparam int W = 32;
  localparam logic [W-1:0] RST = 32'h0000_0013;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_i = 1'b1, flush_i = 1'b0, in_valid_i = 1'b1, out_ready_i = 1'b0;
  logic [W-1:0] in_data_i = 32'hA;
  logic in_ready_o, out_valid_o;
  logic [W-1:0] out_data_o;
  logic [1:0] count_o;
  logic [W-1:0] exp_q[$];
  int compared = 0, mismatched = 0;
  bit was_rst = 1'b0;
  always #5 clk = ~clk;
  pipe_stage_register #(.WIDTH(W), .RESET_DATA(RST)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o)
  );
  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Monitor: compare outputs with the ideal FIFO, pop on delivery, drop contents on flush/reset.
  always @(negedge clk) begin
    int n;
    if (was_rst) begin
      check("rst_data", out_data_o, RST);
      check("rst_valid", {31'd0, out_valid_o}, 0);
      check("rst_count", {30'd0, count_o}, 0);
    end
    if (reset_i) exp_q.delete();
    else begin
      n = exp_q.size();
      check("count", {30'd0, count_o}, n);
      check("valid", {31'd0, out_valid_o}, {31'd0, n != 0});
      check("in_ready", {31'd0, in_ready_o}, {31'd0, SKID ? n < 2 : (n == 0 || out_ready_i)});
      if (out_valid_o && out_ready_i) begin
        if (n == 0) check("spurious_out_count", n, 1);
        else begin
          check("data", out_data_o, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (flush_i) exp_q.delete();
    end
    was_rst = reset_i;
  end
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f,
                      input logic rs, output logic acc);
    @(posedge clk);
    #1;
    in_valid_i = v;
    in_data_i = d;
    out_ready_i = r;
    flush_i = f;
    reset_i = rs;
    @(negedge clk);
    #1;
    acc = v && in_ready_o && !f && !rs;
    if (acc) exp_q.push_back(d);
  endtask
  task automatic send(input logic [W-1:0] d, input logic r);
    logic a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, d, r, 1'b0, 1'b0, a);
    check("send_accepted", {31'd0, a}, 1);
  endtask
  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
  endtask
  initial begin
    logic a6, a7, a;
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, a);
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, a);
    idle(2);
    for (int i = 1; i <= 4; i++) send(i, 1'b1);
    idle(3);
    send(5, 1'b1);
    step(1'b1, 6, 1'b0, 1'b0, 1'b0, a6);
    step(1'b1, a6 ? 7 : 6, 1'b0, 1'b0, 1'b0, a7);
    if (!a6) begin
      send(6, 1'b1);
      send(7, 1'b1);
    end else if (!a7) send(7, 1'b1);
    idle(4);
    send(8, 1'b1);
    step(1'b1, 9, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, a);
    send(32'hC, 1'b1);
    idle(3);
    send(32'h10, 1'b1);
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, a);
    step(1'b1, 32'h12, 1'b1, 1'b1, 1'b1, a);
    idle(4);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0, a);
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
